// File: rtl/cda_rr_arbiter.sv
// Round-robin arbiter with non-preemptive ownership, a hold-length limit and a
// mandatory one-cycle dead cycle between owners. All outputs are registered.
module cda_rr_arbiter #(
    parameter int N        = 86,
    parameter int IDXW     = 7,
    parameter int HOLD_MAX = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            release_pulse,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [IDXW-1:0] IDX_NONE = {IDXW{1'b1}};
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic [7:0]      HOLD_LIM = 8'(HOLD_MAX);
    localparam logic [N-1:0]    ONE_N    = {{(N-1){1'b0}}, 1'b1};

    state_e          state_r, state_s;
    logic [IDXW-1:0] ptr_r, ptr_s;
    logic [7:0]      hold_r, hold_s;
    logic [N-1:0]    gnt_r, gnt_s;
    logic [IDXW-1:0] gnt_idx_r, gnt_idx_s;
    logic            gnt_valid_r, gnt_valid_s;
    logic            timeout_r, timeout_s;
    logic [IDXW-1:0] win_s;
    logic            win_found_s;
    logic            owner_req_s;
    logic            hold_done_s;

    // Round-robin search: first requester at or after ptr, wrapping past N-1.
    always_comb begin
        logic [IDXW:0] cand_s;
        cand_s      = '0;
        win_s       = '0;
        win_found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_r} + (IDXW+1)'(k);
            cand_s = (cand_s >= (IDXW+1)'(N)) ? cand_s - (IDXW+1)'(N) : cand_s;
            if (!win_found_s && req[cand_s[IDXW-1:0]]) begin
                win_s       = cand_s[IDXW-1:0];
                win_found_s = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/OWN/GAP controller.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        hold_s      = hold_r;
        gnt_s       = gnt_r;
        gnt_idx_s   = gnt_idx_r;
        gnt_valid_s = gnt_valid_r;
        timeout_s   = 1'b0;
        owner_req_s = |(req & gnt_r);
        hold_done_s = (hold_r == HOLD_LIM);
        case (state_r)
            ST_IDLE: begin
                if (en && win_found_s) begin
                    state_s     = ST_OWN;
                    gnt_s       = ONE_N << win_s;
                    gnt_idx_s   = win_s;
                    gnt_valid_s = 1'b1;
                    hold_s      = 8'd1;
                    ptr_s       = (win_s == LAST_IDX) ? '0 : win_s + IDXW'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (release_pulse || !owner_req_s || hold_done_s) begin
                    state_s     = ST_GAP;
                    gnt_s       = '0;
                    gnt_idx_s   = IDX_NONE;
                    gnt_valid_s = 1'b0;
                    hold_s      = 8'd0;
                    // Only a pure limit expiry counts as forced; any real release wins.
                    timeout_s   = hold_done_s && !release_pulse && owner_req_s;
                end else begin
                    hold_s = hold_r + 8'd1;
                end
            end
            ST_GAP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s     = ST_IDLE;
                gnt_s       = '0;
                gnt_idx_s   = IDX_NONE;
                gnt_valid_s = 1'b0;
                hold_s      = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            hold_r      <= 8'd0;
            gnt_r       <= '0;
            gnt_idx_r   <= IDX_NONE;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            hold_r      <= hold_s;
            gnt_r       <= gnt_s;
            gnt_idx_r   <= gnt_idx_s;
            gnt_valid_r <= gnt_valid_s;
            timeout_r   <= timeout_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_cda_rr_arbiter.sv
// Bench for cda_rr_arbiter: directed scenarios followed by random traffic,
// all cycles checked against a cycle-level behavioural model.
module tb_cda_rr_arbiter;

    localparam int N    = 86;
    localparam int IDXW = 7;
    localparam int HM   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req;
    logic            release_pulse;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index (-1 = none), dead-cycle flag, pointer, hold length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    cda_rr_arbiter #(.N(N), .IDXW(IDXW), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .release_pulse(release_pulse),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_gap = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner >= 0) begin
            if (release_pulse || !req[m_owner] || m_hold == HM) begin
                m_to    = (m_hold == HM) && !release_pulse && req[m_owner];
                m_owner = -1;
                m_hold  = 0;
                m_gap   = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (en) begin
            w = rr_pick();
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % N;
                m_hold  = 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_gnt;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        chk("gnt", 128'(gnt), 128'(e_gnt));
        chk("gnt_idx", 128'(gnt_idx), (m_owner >= 0) ? 128'(m_owner) : 128'(127));
        chk("gnt_valid", 128'(gnt_valid), 128'(m_owner >= 0));
        chk("timeout", 128'(timeout), 128'(m_to));
        chk("onehot", 128'($countones(gnt) <= 1), 128'(1));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_grant(input int budget, output int idx);
        idx = -1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (gnt_valid === 1'b1) begin
                idx = int'(gnt_idx);
                break;
            end
        end
    endtask

    initial begin
        int got;
        int cnt;
        int exp_order [5];
        exp_order = '{0, 40, 85, 0, 40};
        rst = 1'b1; en = 1'b1; req = '1; release_pulse = 1'b0;

        // Reset dominates full request load
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_gnt", 128'(gnt), 128'(0));
            chk("rst_idx", 128'(gnt_idx), 128'(127));
            chk("rst_valid", 128'(gnt_valid), 128'(0));
            chk("rst_timeout", 128'(timeout), 128'(0));
        end
        rst = 1'b0; req = '0;
        cyc();

        // Single requester, release two cycles into ownership
        req = '0; req[5] = 1'b1;
        cyc();
        chk("single_idx", 128'(gnt_idx), 128'(5));
        chk("single_gnt", 128'(gnt), 128'(1) << 5);
        cyc(); cyc();
        release_pulse = 1'b1;
        cyc();
        release_pulse = 1'b0;
        chk("single_rel_gnt", 128'(gnt), 128'(0));
        chk("single_rel_idx", 128'(gnt_idx), 128'(127));
        req = '0;
        repeat (4) cyc();

        // Fairness from a fresh pointer
        rst = 1'b1; cyc(); rst = 1'b0;
        req = '0; req[0] = 1'b1; req[40] = 1'b1; req[85] = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(8, got);
            chk($sformatf("fair%0d", g), 128'(got), 128'(exp_order[g]));
            release_pulse = 1'b1;
            cyc();
            release_pulse = 1'b0;
        end

        // Wrap past N-1 back to 0
        wait_grant(8, got);
        chk("wrap_85", 128'(got), 128'(85));
        req = '0; req[85] = 1'b1; req[0] = 1'b1;
        release_pulse = 1'b1;
        cyc();
        release_pulse = 1'b0;
        wait_grant(8, got);
        chk("wrap_0", 128'(got), 128'(0));
        req = '0;
        repeat (3) cyc();

        // Forced end after HOLD_MAX cycles
        req[10] = 1'b1;
        wait_grant(8, got);
        chk("to_grant", 128'(got), 128'(10));
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (gnt_valid === 1'b1) cnt++;
            else break;
        end
        chk("to_len", 128'(cnt), 128'(HM));
        chk("to_pulse", 128'(timeout), 128'(1));
        cyc();
        chk("to_clear", 128'(timeout), 128'(0));
        chk("to_idle_valid", 128'(gnt_valid), 128'(0));
        cyc();
        chk("to_regrant_valid", 128'(gnt_valid), 128'(1));
        chk("to_regrant_idx", 128'(gnt_idx), 128'(10));

        // Release on the limit cycle is a normal release
        cyc(); cyc(); cyc();
        release_pulse = 1'b1;
        cyc();
        release_pulse = 1'b0;
        chk("coinc_timeout", 128'(timeout), 128'(0));
        chk("coinc_valid", 128'(gnt_valid), 128'(0));

        // Reset during ownership
        req = '0;
        cyc(); cyc();
        req[3] = 1'b1; req[20] = 1'b1;
        wait_grant(8, got);
        chk("mid_grant", 128'(got), 128'(20));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_valid", 128'(gnt_valid), 128'(0));
        chk("mid_rst_timeout", 128'(timeout), 128'(0));
        wait_grant(8, got);
        chk("mid_rst_from0", 128'(got), 128'(3));

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            en            = ($urandom_range(0, 9) != 0);
            release_pulse = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 1) == 1) req[N-1] = 1'b1;
                if ($urandom_range(0, 1) == 1) req[0] = 1'b1;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cda_rr_arbiter.md
CDA_RR_ARBITER -- requirements
Module: cda_rr_arbiter

Interface
REQ-001 Parameter: N, default 86, number of requesters.
REQ-002 Parameter: IDXW, default 7, width of the encoded grant index.
REQ-003 Parameter: HOLD_MAX, default 255, maximum ownership length in cycles; legal range 1..255.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 Port: en  input  1  arbitration enable; gates new grants only.
REQ-007 Port: req  input  N  per-requester request lines; level-sensitive.
REQ-008 Port: release  input  1  current owner finished; single-cycle pulse.
REQ-009 Port: gnt  output  N  one-hot grant; registered.
REQ-010 Port: gnt_idx  output  IDXW  binary index of the granted requester; 127 when no grant is active.
REQ-011 Port: gnt_valid  output  1  high while a grant is active; equals the OR of gnt.
REQ-012 Port: timeout  output  1  single-cycle pulse when an ownership is forcibly ended.

Function
REQ-013 The block SHALL implement three states.
- IDLE: no owner.
- OWN: one requester holds the grant.
- GAP: a mandatory one-cycle dead cycle after any ownership ends.

REQ-014 In IDLE, when en=1 and req is nonzero at edge t, the block SHALL select the winner and move to OWN.
- gnt, gnt_idx and gnt_valid are registered, so they are visible in cycle t+1.

REQ-015 Winner selection SHALL be round-robin.
- Search starts at priority pointer ptr and proceeds ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- The winner is the first index with req set.

REQ-016 On every grant to index i, ptr SHALL update to i+1, wrapping N-1 to 0.
REQ-017 In IDLE with en=0 or req all zero, the block SHALL stay in IDLE, and gnt, gnt_idx and ptr SHALL hold their current values.
REQ-018 In OWN, the block SHALL hold gnt constant and never pre-empt, including when en=0 or a higher-priority requester appears.

REQ-019 In OWN, a 8-bit hold counter SHALL track ownership length.
- It is 1 in the first OWN cycle and increments each cycle.
- It is cleared on leaving OWN.

REQ-020 OWN SHALL end, moving to GAP at that edge and clearing gnt and gnt_valid and setting gnt_idx=127 in the next cycle, on any of:
- (a) release=1;
- (b) req[owner]=0;
- (c) hold counter == HOLD_MAX.

REQ-021 Exit by (c) with release=0 and req[owner]=1 SHALL assert timeout for exactly the first GAP cycle.
REQ-022 When (a) or (b) coincides with (c), the exit SHALL count as a normal release and timeout SHALL stay 0.
REQ-023 GAP SHALL last exactly one cycle and then enter IDLE, so the earliest regrant after a release at edge t is visible in cycle t+3.
REQ-024 The block SHALL ignore release outside OWN.
REQ-025 gnt_idx SHALL always equal the one-hot-to-binary encoding of gnt.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set:
- state=IDLE, ptr=0, hold counter=0;
- gnt=0, gnt_idx=127, gnt_valid=0, timeout=0.

REQ-028 Reset asserted during OWN SHALL drop the grant in the next cycle with no timeout pulse; it takes priority over all other inputs.
REQ-029 The first grant after reset SHALL search from index 0.

Verification
REQ-030 Reset test: rst=1 with req all ones and en=1 -> every cycle shows gnt=0, gnt_idx=127, gnt_valid=0, timeout=0.
REQ-031 Single-requester test: req[5]=1 at edge t with en=1 -> gnt=bit 5, gnt_idx=5 in cycle t+1; release at edge t+3 -> gnt=0, gnt_idx=127 in cycle t+4.
REQ-032 Fairness test: req bits 0, 40 and 85 held high, release pulsed on each grant -> grant order is 0, 40, 85, 0, 40.
REQ-033 Wrap test: after a grant to index 85, requests on 85 and 0 -> grant goes to 0.
REQ-034 Timeout test: HOLD_MAX=4, req[10] held high, no release -> gnt_valid high for exactly 4 cycles, then timeout=1 for one cycle, then index 10 is regranted one cycle after GAP.
REQ-035 Mid-operation tests:
- rst pulsed during OWN -> grant clears next cycle, no timeout pulse, next grant searches from 0.
- release coinciding with the HOLD_MAX cycle -> timeout stays 0.
